// File: rtl/dac_spi_arbiter.sv
// Two-requester SPI master for a dual-slave DAC: fair arbitration between the CPU (req0)
// and the hardware trim loop (req1), then a mode-0 frame with setup, hold and inter-frame gap.
module dac_spi_arbiter #(
    parameter int CLK_DIV = 4,
    parameter int WIDTH   = 24
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             req0_valid,
    input  logic             req0_cs,
    input  logic [WIDTH-1:0] req0_wdata,
    output logic             req0_ready,
    output logic             req0_done,
    output logic [WIDTH-1:0] req0_rdata,
    input  logic             req1_valid,
    input  logic             req1_cs,
    input  logic [WIDTH-1:0] req1_wdata,
    output logic             req1_ready,
    output logic             req1_done,
    output logic [WIDTH-1:0] req1_rdata,
    output logic             dac_SCLK,
    output logic             dac_MOSI,
    output logic [1:0]       dac_SS_n,
    input  logic             dac_MISO,
    output logic             busy
);

    // Sized for CLK_DIV=255 (GAP counts to 509) and WIDTH=32.
    localparam int DW = 9;
    localparam int BW = 6;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             half_q, half_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic             cs_q, cs_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] rdata0_q, rdata0_d;
    logic [WIDTH-1:0] rdata1_q, rdata1_d;
    logic             grant;
    logic             div_end;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            half_q   <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
            cs_q     <= 1'b0;
            last_q   <= 1'b1;
            done_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            half_q   <= half_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            cs_q     <= cs_d;
            last_q   <= last_d;
            done_q   <= done_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // On a tie the requester that was not served last wins.
    assign grant      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign req0_ready = reset_reset_n && (state_q == IDLE) && req0_valid && !grant;
    assign req1_ready = reset_reset_n && (state_q == IDLE) && req1_valid && grant;
    assign div_end    = (div_q == DW'(CLK_DIV - 1));

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        half_d   = half_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        cs_d     = cs_q;
        last_d   = last_q;
        done_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    state_d = SETUP;
                    div_d   = '0;
                    last_d  = grant;
                    cs_d    = grant ? req1_cs : req0_cs;
                    tx_d    = grant ? req1_wdata : req0_wdata;
                end
            end
            SETUP: begin
                if (div_end) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    bit_d   = '0;
                    half_d  = 1'b0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SHIFT: begin
                if (half_q && div_q == '0)
                    rx_d = {rx_q[WIDTH-2:0], dac_MISO};
                if (div_end) begin
                    div_d  = '0;
                    half_d = ~half_q;
                    // Next bit appears exactly when SCLK falls.
                    if (half_q) begin
                        tx_d = tx_q << 1;
                        if (bit_q == BW'(WIDTH - 1))
                            state_d = HOLD;
                        else
                            bit_d = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HOLD: begin
                if (div_end) begin
                    state_d = GAP;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            GAP: begin
                if (div_q == DW'(2 * CLK_DIV - 1)) begin
                    state_d = IDLE;
                    div_d   = '0;
                    done_d  = 1'b1;
                    if (last_q)
                        rdata1_d = rx_q;
                    else
                        rdata0_d = rx_q;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign dac_SCLK   = (state_q == SHIFT) && half_q;
    assign dac_MOSI   = (state_q == SETUP || state_q == SHIFT || state_q == HOLD) ? tx_q[WIDTH-1] : 1'b0;
    assign dac_SS_n   = (state_q == SETUP || state_q == SHIFT || state_q == HOLD)
                        ? (cs_q ? 2'b01 : 2'b10) : 2'b11;
    assign req0_done  = done_q && !last_q;
    assign req1_done  = done_q && last_q;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// Scoreboard bench: accepted frames are queued with their expected SPI view and
// checked when the matching done pulse appears.
module tb_dac_spi_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: CLK_DIV=4, WIDTH=24, MISO looped back from MOSI
    logic        r0v = 0, r0cs = 0, r1v = 0, r1cs = 0;
    logic [23:0] r0wd = '0, r1wd = '0;
    logic        r0rdy, r0done, r1rdy, r1done;
    logic [23:0] r0rd, r1rd;
    logic        sclk, mosi, busy;
    logic [1:0]  ss;

    dac_spi_arbiter #(.CLK_DIV(4), .WIDTH(24)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .req0_valid(r0v), .req0_cs(r0cs), .req0_wdata(r0wd),
        .req0_ready(r0rdy), .req0_done(r0done), .req0_rdata(r0rd),
        .req1_valid(r1v), .req1_cs(r1cs), .req1_wdata(r1wd),
        .req1_ready(r1rdy), .req1_done(r1done), .req1_rdata(r1rd),
        .dac_SCLK(sclk), .dac_MOSI(mosi), .dac_SS_n(ss), .dac_MISO(mosi), .busy(busy)
    );

    // Instance B: CLK_DIV=2, WIDTH=8, MISO tied high
    logic       b_r0v = 0, b_r0cs = 0, b_r1v = 0, b_r1cs = 0;
    logic [7:0] b_r0wd = '0, b_r1wd = '0;
    logic       b_r0rdy, b_r0done, b_r1rdy, b_r1done;
    logic [7:0] b_r0rd, b_r1rd;
    logic       b_sclk, b_mosi, b_busy;
    logic [1:0] b_ss;

    dac_spi_arbiter #(.CLK_DIV(2), .WIDTH(8)) dut_b (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .req0_valid(b_r0v), .req0_cs(b_r0cs), .req0_wdata(b_r0wd),
        .req0_ready(b_r0rdy), .req0_done(b_r0done), .req0_rdata(b_r0rd),
        .req1_valid(b_r1v), .req1_cs(b_r1cs), .req1_wdata(b_r1wd),
        .req1_ready(b_r1rdy), .req1_done(b_r1done), .req1_rdata(b_r1rd),
        .dac_SCLK(b_sclk), .dac_MOSI(b_mosi), .dac_SS_n(b_ss), .dac_MISO(1'b1), .busy(b_busy)
    );

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        id;
        logic        cs;
        logic [23:0] data;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          done_cnt = 0, acc_cnt = 0, edges = 0, last_done_cyc = -1000;
    int          ovl = 0, bad_ss = 0;
    logic [23:0] mosi_acc = '0;
    logic [1:0]  ss_seen = 2'b11;
    logic        prev_sclk = 0, last_m = 1, b2b = 0, b2b_skip = 0, id_m, w_m;

    // Instance A monitor/scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            edges     = 0;
            mosi_acc  = '0;
            prev_sclk = 0;
            last_m    = 1;
            ss_seen   = 2'b11;
        end else begin
            if (r0rdy && r1rdy) ovl++;
            if (ss == 2'b00) bad_ss++;
            if (sclk && !prev_sclk) begin
                mosi_acc = {mosi_acc[22:0], mosi};
                edges++;
            end
            prev_sclk = sclk;
            if (ss != 2'b11) ss_seen = ss;
            if (r0done || r1done) begin
                done_cnt++;
                if (q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("done_id", {31'd0, r1done}, {31'd0, e.id});
                    check("rdata", e.id ? r1rd : r0rd, e.data);
                    check("mosi_bits", mosi_acc, e.data);
                    check("sclk_edges", edges, 24);
                    check("ss_n", ss_seen, e.cs ? 2'b01 : 2'b10);
                    check("latency", cyc - e.acc, 209);
                end
                last_done_cyc = cyc;
                edges   = 0;
                ss_seen = 2'b11;
            end
            if ((r0v && r0rdy) || (r1v && r1rdy)) begin
                id_m = r1rdy;
                w_m  = (r0v && r1v) ? ~last_m : r1v;
                check("grant", {31'd0, id_m}, {31'd0, w_m});
                if (b2b) begin
                    if (!b2b_skip) check("back_to_back", cyc, last_done_cyc);
                    b2b_skip = 0;
                end
                last_m = id_m;
                acc_cnt++;
                q.push_back('{id: id_m, cs: id_m ? r1cs : r0cs, data: id_m ? r1wd : r0wd, acc: cyc});
            end
        end
    end

    // Instance B monitor
    int         b_acc = 0, b_edges = 0, b_last_rise = -1, b_period = 0, b_done_cnt = 0;
    logic [7:0] b_data = '0, b_mosi_acc = '0;
    logic       b_prev = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (b_sclk && !b_prev) begin
                if (b_last_rise >= 0) b_period = cyc - b_last_rise;
                b_last_rise = cyc;
                b_edges++;
                b_mosi_acc = {b_mosi_acc[6:0], b_mosi};
            end
            b_prev = b_sclk;
            if (b_r0done) begin
                b_done_cnt++;
                check("b_latency", cyc - b_acc, 41);
                check("b_rdata", b_r0rd, 8'hFF);
                check("b_sclk_period", b_period, 4);
                check("b_sclk_edges", b_edges, 8);
                check("b_mosi_bits", b_mosi_acc, b_data);
            end
            if (b_r0v && b_r0rdy) begin
                b_acc       = cyc;
                b_data      = b_r0wd;
                b_edges     = 0;
                b_last_rise = -1;
                b_mosi_acc  = '0;
            end
        end
    end

    task automatic send(input logic id, input logic [23:0] d, input logic c);
        int g = 0;
        @(posedge clk); #1;
        if (id) begin r1v = 1; r1wd = d; r1cs = c; end
        else    begin r0v = 1; r0wd = d; r0cs = c; end
        do begin
            @(negedge clk);
            g++;
        end while (!(id ? r1rdy : r0rdy) && g < 2000);
        if (g >= 2000) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        if (id) r1v = 0; else r0v = 0;
    endtask

    task automatic drain();
        int g = 0;
        while ((q.size() != 0 || busy) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) check("drain_timeout", 0, 1);
    endtask

    task automatic send_b(input logic [7:0] d);
        int g = 0;
        int n0 = b_done_cnt;
        @(posedge clk); #1;
        b_r0v = 1; b_r0wd = d;
        do begin
            @(negedge clk);
            g++;
        end while (!b_r0rdy && g < 500);
        @(posedge clk); #1;
        b_r0v = 0;
        while (b_done_cnt == n0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) check("b_timeout", 0, 1);
    endtask

    initial begin
        int n, g, dcount;
        logic a0, a1;

        // Reset with both requesters already valid
        r0v = 1; r0cs = 0; r0wd = 24'h111111;
        r1v = 1; r1cs = 1; r1wd = 24'h222222;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss_n", ss, 2'b11);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", {r0rdy, r1rdy}, 2'b00);
        check("rst_done", {r0done, r1done}, 2'b00);
        check("rst_rdata0", r0rd, 0);
        check("rst_rdata1", r1rd, 0);

        // Both continuously valid for six frames: alternating grants, back-to-back
        b2b = 1; b2b_skip = 1; n = 0; g = 0;
        rst_n = 1;
        while (n < 6 && g < 5000) begin
            @(negedge clk);
            a0 = r0rdy; a1 = r1rdy;
            @(posedge clk); #1;
            if (a0) r0wd = 24'($urandom);
            if (a1) r1wd = 24'($urandom);
            n += int'(a0) + int'(a1);
            g++;
        end
        r0v = 0; r1v = 0;
        check("six_accepts", n, 6);
        drain();
        b2b = 0;
        check("ready_overlap", ovl, 0);
        check("ss_both_low", bad_ss, 0);

        // Loopback frame; wdata/cs changed mid-frame must not leak into it
        send(0, 24'h123456, 0);
        repeat (60) @(posedge clk);
        #1 r0wd = 24'hABCDEF; r0cs = 1;
        drain();
        check("rdata0_hold", r0rd, 24'h123456);

        send(1, 24'h5A5A5A, 0);
        drain();

        // Abort mid-frame with an asynchronous reset at bit 10
        send(0, 24'hA5A5A5, 0);
        g = 0;
        while (edges < 10 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 1000) check("bit10_timeout", 0, 1);
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        check("abort_ss_n", ss, 2'b11);
        check("abort_sclk", sclk, 0);
        check("abort_mosi", mosi, 0);
        check("abort_busy", busy, 0);
        dcount = done_cnt;
        repeat (5) @(posedge clk);
        #1 rst_n = 1;
        repeat (250) @(posedge clk);
        check("no_done_after_abort", done_cnt, dcount);

        send(1, 24'h0F1E2D, 1);
        drain();
        check("done_total", done_cnt, 9);

        // Small instance: CLK_DIV=2, WIDTH=8
        send_b(8'h3C);
        send_b(8'h81);
        check("b_done_total", b_done_cnt, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
